// File: rtl/idct8_chen_ts.sv
// ---------------------------------------------------------------------------
// idct8_chen_ts -- time-shared 8-point 1-D inverse DCT
//
// Purpose:
//   Decode-side counterpart of the 8-point forward DCT. A coefficient vector
//   X[0..7] is accepted through a valid/ready handshake. One spatial sample
//   x[idx] is then computed per cycle over 8 cycles, using a single bank of
//   8 multipliers whose cosine constants are selected by idx. The finished
//   sample vector x[0..7] is presented under a valid/ready handshake.
//   Two instances plus a transpose buffer make up the 2-D IDCT.
//
//   x[n] = (sum_k X[k]*K[n][k] + 2^(CONST_W-2)) >>> (CONST_W-1)
//   K[n][k] = round(0.5*C(k)*cos((2n+1)k*pi/16) * 2^(CONST_W-1))
//
// Configuration macro:
//   IDCT8_SAT_EN  defined   -> each rounded row sum saturates to IN_W bits
//                 undefined -> the low IN_W bits are kept (two's-complement wrap)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   coefficient vector valid
//   in_ready   out  block can accept a vector (IDLE only)
//   in0..in7   in   IN_W signed coefficients X[0]..X[7]
//   out_valid  out  sample vector valid (DONE only)
//   out_ready  in   downstream accepts the vector
//   out0..out7 out  IN_W signed samples x[0]..x[7]
// ---------------------------------------------------------------------------
module idct8_chen_ts #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in0,
  input  logic [IN_W-1:0] in1,
  input  logic [IN_W-1:0] in2,
  input  logic [IN_W-1:0] in3,
  input  logic [IN_W-1:0] in4,
  input  logic [IN_W-1:0] in5,
  input  logic [IN_W-1:0] in6,
  input  logic [IN_W-1:0] in7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] out0,
  output logic [IN_W-1:0] out1,
  output logic [IN_W-1:0] out2,
  output logic [IN_W-1:0] out3,
  output logic [IN_W-1:0] out4,
  output logic [IN_W-1:0] out5,
  output logic [IN_W-1:0] out6,
  output logic [IN_W-1:0] out7
);

  localparam int  PROD_W = IN_W + CONST_W;
  localparam int  ACC_W  = IN_W + CONST_W + 3;
  localparam real PI     = 3.14159265358979323846;

  // Rounding offset 2^(CONST_W-2), i.e. one half LSB of the shifted result.
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-CONST_W+1){1'b0}}, 1'b1, {(CONST_W-2){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic signed [IN_W-1:0]    x_q   [8];
  logic signed [IN_W-1:0]    out_q [8];
  logic [IN_W-1:0]           inVec [8];
  logic signed [CONST_W-1:0] kRow  [8][8];
  logic signed [CONST_W-1:0] kSel  [8];
  logic signed [PROD_W-1:0]  prod  [8];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   accRnd;
  logic signed [ACC_W-1:0]   accShift;
  logic signed [IN_W-1:0]    rowOut;
  logic                      accept;

  // Cosine constant generator, evaluated only at elaboration so the table
  // tracks CONST_W. Rounds half away from zero.
  function automatic logic signed [CONST_W-1:0] kConst(input int n, input int k);
    real ck;
    real v;
    int  r;
    ck = (k == 0) ? (1.0 / $sqrt(2.0)) : 1.0;
    v  = 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0) * (2.0 ** (CONST_W - 1));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return CONST_W'(r);
  endfunction

  for (genvar n = 0; n < 8; n++) begin : gRow
    for (genvar k = 0; k < 8; k++) begin : gCol
      localparam logic signed [CONST_W-1:0] KV = kConst(n, k);
      assign kRow[n][k] = KV;
    end
  end

  assign inVec[0] = in0;
  assign inVec[1] = in1;
  assign inVec[2] = in2;
  assign inVec[3] = in3;
  assign inVec[4] = in4;
  assign inVec[5] = in5;
  assign inVec[6] = in6;
  assign inVec[7] = in7;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = (state_q == IDLE) && in_valid;

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign out4 = out_q[4];
  assign out5 = out_q[5];
  assign out6 = out_q[6];
  assign out7 = out_q[7];

  // Shared multiplier bank: the row of constants for the current idx is
  // muxed onto the 8 multipliers, and the products are summed at full width.
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      kSel[k] = kRow[idx_q][k];
      prod[k] = PROD_W'(x_q[k]) * PROD_W'(kSel[k]);
      acc     = acc + ACC_W'(prod[k]);
    end
    accRnd   = acc + RND;
    accShift = accRnd >>> (CONST_W - 1);
  end

`ifdef IDCT8_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  always_comb begin
    if (accShift > SAT_MAX)      rowOut = SAT_MAX[IN_W-1:0];
    else if (accShift < SAT_MIN) rowOut = SAT_MIN[IN_W-1:0];
    else                         rowOut = accShift[IN_W-1:0];
  end
`else
  // Wrapping build: the bits above IN_W are intentionally discarded.
  logic unusedHighBits;
  assign unusedHighBits = ^accShift[ACC_W-1:IN_W];
  assign rowOut         = accShift[IN_W-1:0];
`endif

  // Next-state logic. idx wraps from 7 back to 0 on its own, so DONE and
  // IDLE always see idx=0 without an explicit clear.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          idx_d   = '0;
        end
      end
      CALC: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, coefficient capture and per-row result registers. The
  // async reset also clears the outputs so an aborted vector leaves nothing
  // behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < 8; k++) begin
        x_q[k]   <= '0;
        out_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        for (int k = 0; k < 8; k++) x_q[k] <= inVec[k];
      end
      if (state_q == CALC) out_q[idx_q] <= rowOut;
    end
  end

endmodule
